// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Holds the program counter, drives the
//            instruction-memory byte address, captures the combinationally
//            returned word into a registered fetch/decode boundary with a
//            valid/ready handshake, and applies PC redirects with flush and
//            misaligned-target detection.
// Ports    : clk_i / rst_ni          clock, async active-low reset
//            imem_addr_o / imem_data_i  memory address out, word back
//            redirect_valid_i / redirect_pc_i  new-PC request and target
//            inst_valid_o / inst_ready_i  handshake toward decode
//            inst_o / pc_o / pc_four_o  boundary word, its PC, PC + 4
//            misalign_o              high while halted on a misaligned target
//            fetch_cnt_o             completed handshake count
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int          IMEM_W   = 14,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic [IMEM_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_data_i,
    input  logic              redirect_valid_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [31:0]       inst_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       pc_four_o,
    output logic              misalign_o,
    output logic [31:0]       fetch_cnt_o
);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    localparam logic [31:0] c_STEP = 32'd4;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_pc_out;
    logic [31:0] r_pc_four;
    logic        r_misalign;
    logic [31:0] r_cnt;

    logic w_load;
    logic w_xfer;

    // The boundary register can accept a new word when empty or draining.
    assign w_load = (r_state == S_RUN) && (!r_valid || inst_ready_i);
    assign w_xfer = r_valid && inst_ready_i;

    // Low bits forced to zero so a misaligned target held in FAULT never
    // produces an unaligned memory address.
    assign imem_addr_o = {r_pc[IMEM_W-1:2], 2'b00};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_WAIT;
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_inst     <= 32'd0;
            r_pc_out   <= 32'd0;
            r_pc_four  <= c_STEP;
            r_misalign <= 1'b0;
            r_cnt      <= 32'd0;
        end else begin
            // A transfer completes even when a redirect flushes the register
            // in the same cycle.
            if (w_xfer) begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (redirect_valid_i) begin
                r_valid <= 1'b0;
                r_pc    <= redirect_pc_i;
                if (redirect_pc_i[1:0] == 2'b00) begin
                    r_state    <= S_RUN;
                    r_misalign <= 1'b0;
                end else begin
                    r_state    <= S_FAULT;
                    r_misalign <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_WAIT: begin
                        r_state <= S_RUN;
                    end
                    S_RUN: begin
                        if (w_load) begin
                            r_inst    <= imem_data_i;
                            r_pc_out  <= r_pc;
                            r_pc_four <= r_pc + c_STEP;
                            r_valid   <= 1'b1;
                            r_pc      <= r_pc + c_STEP;
                        end
                    end
                    S_FAULT: begin
                        r_valid <= 1'b0;
                    end
                    default: begin
                        r_state <= S_WAIT;
                    end
                endcase
            end
        end
    end

    assign inst_valid_o = r_valid;
    assign inst_o       = r_inst;
    assign pc_o         = r_pc_out;
    assign pc_four_o    = r_pc_four;
    assign misalign_o   = r_misalign;
    assign fetch_cnt_o  = r_cnt;

endmodule
`default_nettype wire
